// File: rtl/matmul_stream_adapter.sv
// Serial valid/ready front/back end for the matrix-multiply host: loads A and B
// element by element, kicks the host, captures its result and streams it back out.
module matmul_stream_adapter #(
    parameter int MATRIX_SIZE    = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int RESULT_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [DATA_WIDTH-1:0]                             in_data,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    output logic [RESULT_WIDTH-1:0]                           out_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic                                              out_last,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     mat_a_flat,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     mat_b_flat,
    output logic                                              start_mult,
    input  logic                                              mult_done,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*RESULT_WIDTH-1:0]   mat_c_flat,
    output logic                                              busy,
    output logic                                              timeout_err
);

    localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IW = $clog2(NN) + 1;
    localparam int AW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
    localparam logic [15:0]   TMO      = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [IW-1:0]           r_idx;
    logic [15:0]             r_cnt;
    logic                    r_timeoutErr;
    logic [DATA_WIDTH-1:0]   r_a [NN];
    logic [DATA_WIDTH-1:0]   r_b [NN];
    logic [RESULT_WIDTH-1:0] r_c [NN];

    logic                    w_accept;
    logic                    w_outFire;
    logic                    w_idxLast;
    logic                    w_timeoutHit;
    logic [15:0]             w_cntNext;
    logic [AW-1:0]           w_addr;

    assign w_addr       = r_idx[AW-1:0];
    assign w_idxLast    = (r_idx == LAST_IDX);
    assign w_cntNext    = r_cnt + 16'd1;
    assign w_timeoutHit = (w_cntNext == TMO);

    assign in_ready    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = (r_state == S_DRAIN);
    assign w_outFire   = out_valid && out_ready;
    assign out_data    = r_c[w_addr];
    assign out_last    = out_valid && w_idxLast;
    assign start_mult  = (r_state == S_START);
    assign busy        = (r_state != S_LOAD_A);
    assign timeout_err = r_timeoutErr;

    for (genvar k = 0; k < NN; k++) begin : g_flat
        assign mat_a_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_a[k];
        assign mat_b_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_b[k];
    end

    // A done arriving on the very cycle the limit is reached takes priority over the abort.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_LOAD_A:  if (w_accept && w_idxLast) w_stateNext = S_LOAD_B;
            S_LOAD_B:  if (w_accept && w_idxLast) w_stateNext = S_START;
            S_START:   w_stateNext = S_WAIT;
            S_WAIT: begin
                if (mult_done)         w_stateNext = S_CAPTURE;
                else if (w_timeoutHit) w_stateNext = S_LOAD_A;
            end
            S_CAPTURE: w_stateNext = S_DRAIN;
            S_DRAIN:   if (w_outFire && w_idxLast) w_stateNext = S_LOAD_A;
            default:   w_stateNext = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_LOAD_A;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_timeoutErr <= 1'b0;
            for (int k = 0; k < NN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= '0;
            end
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                S_LOAD_A: begin
                    if (w_accept) begin
                        r_a[w_addr]  <= in_data;
                        r_idx        <= w_idxLast ? '0 : r_idx + 1'b1;
                        r_timeoutErr <= 1'b0;
                    end
                end
                S_LOAD_B: begin
                    if (w_accept) begin
                        r_b[w_addr] <= in_data;
                        r_idx       <= w_idxLast ? '0 : r_idx + 1'b1;
                    end
                end
                S_START: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= w_cntNext;
                    if (!mult_done && w_timeoutHit) begin
                        r_timeoutErr <= 1'b1;
                        r_idx        <= '0;
                    end
                end
                S_CAPTURE: begin
                    for (int k = 0; k < NN; k++) begin
                        r_c[k] <= mat_c_flat[k*RESULT_WIDTH +: RESULT_WIDTH];
                    end
                    r_idx <= '0;
                end
                S_DRAIN: begin
                    if (w_outFire) r_idx <= w_idxLast ? '0 : r_idx + 1'b1;
                end
                default: r_idx <= '0;
            endcase
        end
    end

endmodule
